// File: rtl/sub16_pkg.sv
// Shared types and helpers for the digit-serial 16-bit subtractor.
// Holds the datapath width, FSM state encoding and DIGIT_W legality helpers.
package sub16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int num_digits(input int digit_w);
    return DATA_W / digit_w;
  endfunction

  // Only digit widths that tile the word exactly are usable.
  function automatic bit digit_w_legal(input int digit_w);
    return (digit_w >= 1) && (digit_w <= DATA_W) && ((DATA_W % digit_w) == 0);
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT_W-bit ripple-borrow subtractor slice.
// Computes d = a - b - bin and the borrow leaving the digit.
module digit_subtractor #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] chain;

  always_comb begin
    chain    = '0;
    d        = '0;
    chain[0] = bin;
    for (int i = 0; i < DIGIT_W; i++) begin
      d[i]         = a[i] ^ b[i] ^ chain[i];
      chain[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
    end
    bout = chain[DIGIT_W];
  end

endmodule

// File: rtl/sixteen_bit_subtractor_seq.sv
// Sequential 16-bit subtractor: one DIGIT_W-bit digit per clock, LSB first,
// with valid/ready handshakes on both sides and registered result flags.
module sixteen_bit_subtractor_seq
  import sub16_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              borrow_out,
  output logic              overflow
);

  localparam int N = num_digits(DIGIT_W);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!digit_w_legal(DIGIT_W)) begin : g_bad_digit_w
    $error("DIGIT_W must divide 16");
  end

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;
  logic              borrow;
  logic              a_msb;
  logic              b_msb;
  logic [DIGIT_W-1:0] d;
  logic              bout;

  digit_subtractor #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .a   (a_sh[DIGIT_W-1:0]),
    .b   (b_sh[DIGIT_W-1:0]),
    .bin (borrow),
    .d   (d),
    .bout(bout)
  );

  // Working accumulator with the current digit merged in; the visible diff
  // register only takes this on the last digit so outputs stay put in CALC.
  always_comb begin
    acc_next = acc;
    acc_next[int'(cnt)*DIGIT_W +: DIGIT_W] = d;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)     state_next = CALC;
      CALC:    if (cnt == LAST)  state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= op_a;
            b_sh   <= op_b;
            a_msb  <= op_a[DATA_W-1];
            b_msb  <= op_b[DATA_W-1];
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          acc    <= acc_next;
          borrow <= bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff       <= acc_next;
            borrow_out <= bout;
            overflow   <= (a_msb != b_msb) && (acc_next[DATA_W-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_sixteen_bit_subtractor_seq.sv
// Self-checking bench: directed cases on a DIGIT_W=4 instance plus random
// sweeps on DIGIT_W=1 and DIGIT_W=16 instances against an arithmetic model.
module tb_sixteen_bit_subtractor_seq;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [2:0]  borrow_o;
  logic [2:0]  ovf_o;
  logic [15:0] op_a   [3];
  logic [15:0] op_b   [3];
  logic [15:0] diff_o [3];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sixteen_bit_subtractor_seq #(
      .DIGIT_W(g == 0 ? 4 : (g == 1 ? 1 : 16))
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op_a      (op_a[g]),
      .op_b      (op_b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .diff      (diff_o[g]),
      .borrow_out(borrow_o[g]),
      .overflow  (ovf_o[g])
    );
  end

  function automatic int latencyOf(input int idx);
    case (idx)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void refModel(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] d, output logic bo,
                                   output logic ov);
    int ud;
    int sd;
    ud = int'(a) - int'(b);
    sd = int'($signed(a)) - int'($signed(b));
    d  = ud[15:0];
    bo = (ud < 0);
    ov = (sd > 32767) || (sd < -32768);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, measure latency, check result, drain.
  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] exp_d;
    logic        exp_bo;
    logic        exp_ov;
    int          waited;
    int          lat;
    refModel(a, b, exp_d, exp_bo, exp_ov);
    waited = 0;
    while (!in_ready[idx] && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("in_ready_before_op", 32'(in_ready[idx]), 32'd1);
    op_a[idx]     = a;
    op_b[idx]     = b;
    in_valid[idx] = 1'b1;
    tick();
    in_valid[idx] = 1'b0;
    op_a[idx]     = 16'($urandom);
    op_b[idx]     = 16'($urandom);
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(latencyOf(idx)));
    checkOutput("diff", 32'(diff_o[idx]), 32'(exp_d));
    checkOutput("borrow_out", 32'(borrow_o[idx]), 32'(exp_bo));
    checkOutput("overflow", 32'(ovf_o[idx]), 32'(exp_ov));
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
    checkOutput("out_valid_after_xfer", 32'(out_valid[idx]), 32'd0);
    checkOutput("in_ready_after_xfer", 32'(in_ready[idx]), 32'd1);
  endtask

  initial begin
    logic [15:0] exp_d;
    logic        exp_bo;
    logic        exp_ov;
    logic [15:0] held_d;
    int          seen;
    int          waited;

    rst_n     = 3'b000;
    in_valid  = 3'b000;
    out_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    tick();
    tick();
    rst_n = 3'b111;
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset_in_ready", 32'(in_ready[i]), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid[i]), 32'd0);
      checkOutput("reset_diff", 32'(diff_o[i]), 32'd0);
      checkOutput("reset_flags", 32'({borrow_o[i], ovf_o[i]}), 32'd0);
    end

    $display("[TB] directed cases, DIGIT_W=4");
    applyStimulus(0, 16'h0005, 16'h0003);
    applyStimulus(0, 16'h0000, 16'h0001);
    applyStimulus(0, 16'h8000, 16'h0001);
    applyStimulus(0, 16'h7FFF, 16'hFFFF);

    $display("[TB] reset during second CALC cycle");
    op_a[0]     = 16'h4321;
    op_b[0]     = 16'h1111;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst_n[0]     = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    rst_n[0]     = 1'b1;
    out_ready[0] = 1'b0;
    checkOutput("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("rst_mid_diff", 32'(diff_o[0]), 32'd0);
    checkOutput("rst_mid_borrow", 32'(borrow_o[0]), 32'd0);
    checkOutput("rst_mid_overflow", 32'(ovf_o[0]), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    checkOutput("rst_mid_no_result", 32'(seen), 32'd0);
    applyStimulus(0, 16'h1234, 16'h0234);

    $display("[TB] backpressure with ignored inputs");
    refModel(16'h9ABC, 16'h1234, exp_d, exp_bo, exp_ov);
    op_a[0]     = 16'h9ABC;
    op_b[0]     = 16'h1234;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    waited = 0;
    while (!out_valid[0] && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("bp_reach_done", 32'(out_valid[0]), 32'd1);
    held_d = diff_o[0];
    checkOutput("bp_diff", 32'(held_d), 32'(exp_d));
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = ~in_valid[0];
      op_a[0]     = 16'($urandom);
      tick();
      checkOutput("bp_out_valid", 32'(out_valid[0]), 32'd1);
      checkOutput("bp_diff_stable", 32'(diff_o[0]), 32'(exp_d));
      checkOutput("bp_flags_stable", 32'({borrow_o[0], ovf_o[0]}), 32'({exp_bo, exp_ov}));
      checkOutput("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    checkOutput("bp_xfer_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("bp_xfer_in_ready", 32'(in_ready[0]), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[0] || !in_ready[0]) seen++;
    end
    out_ready[0] = 1'b0;
    checkOutput("bp_single_transfer", 32'(seen), 32'd0);

    $display("[TB] random sweep, DIGIT_W=1");
    for (int i = 0; i < 1000; i++) applyStimulus(1, 16'($urandom), 16'($urandom));
    $display("[TB] random sweep, DIGIT_W=16");
    for (int i = 0; i < 1000; i++) applyStimulus(2, 16'($urandom), 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
